fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier; next generation of the single-shot 16-bit multiplier used in the neuron datapath.
- Accepts one operand pair per cycle with a 3-cycle fixed latency.
- Exponent and mantissa widths are configurable; default is the 16-bit half format (1/5/10).
- A tag travels alongside each operation so neuron/channel IDs stay paired with their results; a hold input stalls the whole pipe.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa width (hidden bit not stored).
- TAG_W, 4, width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_A  in  1+EXP_W+MAN_W  operand A: {sign, exp, man}.
- in_B  in  1+EXP_W+MAN_W  operand B.
- in_Tag  in  TAG_W  sideband tag for this operation.
- in_En  in  1  operand valid; a pair is accepted on a rising clk edge with in_En=1 and in_Hold=0.
- in_Hold  in  1  pipeline freeze (downstream not ready).
- out_Out  out  1+EXP_W+MAN_W  product.
- out_Tag  out  TAG_W  tag of out_Out.
- out_Ready  out  1  out_Out/out_Tag valid this cycle.

Behaviour:
- Reset: rst sampled high clears every stage valid bit. out_Ready=0, out_Out=0, out_Tag=0. Reset mid-operation discards all in-flight ops.
- Latency: pair accepted at edge N appears with out_Ready=1 after edge N+3, provided in_Hold stays 0. Throughput is 1 per cycle.
- Pipeline stages:
  - S1: unpack, classify (zero/inf/NaN/normal), sign = sA^sB, exponent sum eA+eB-bias at EXP_W+2 bits signed.
  - S2: (MAN_W+1)x(MAN_W+1) significand multiply. If product bit 2*MAN_W+1 is set, shift right 1 and exp+1.
  - S3: round, detect overflow/underflow, pack.
- Hold: in_Hold=1 freezes all stage registers and outputs. in_En is ignored and nothing is accepted. out_Ready holds its value, so a valid result is presented until hold drops. No bubbles are inserted and no data is lost.
- Special values, in priority order:
  - Any NaN operand, or zero x inf → canonical qNaN: sign 0, exp all 1s, man MSB 1, rest 0 (0x7E00 at defaults).
  - Inf x nonzero → inf with the computed sign.
  - Zero x finite → zero with the computed sign.
  - Subnormal inputs are treated as zero (flush-to-zero).
- Overflow: biased result exp ≥ 2^EXP_W-1, after rounding → inf with sign.
- Underflow: biased result exp ≤ 0 → signed zero (no subnormal outputs).
- Rounding carry out of the mantissa increments the exponent. Overflow is re-checked after this increment.
- Exponent arithmetic: signed width EXP_W+2, so no wrap-around is possible before the range checks.

Optional Feature:
- Macro FP_MUL_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using guard bit and OR of the lower bits as sticky.
- Undefined: truncate (round toward zero); the rounding incrementer is not built.
- Latency is 3 in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - FP_CLASS enum: ZERO, NORM, INF, NAN.
  - Width functions: total width = 1+EXP_W+MAN_W; bias.
  - Canonical qNaN/inf constant builders.
- One sub-module, fp_unpack: combinational field split and classify, instantiated twice in S1.

Test Plan:
- 0x3C00 x 0x3C00, tag 3 → out 0x3C00, tag 3, out_Ready exactly 3 edges after accept.
- 0x57B7 x 0xD7B7 (123.44 x -123.44) → 0xF371 with FP_MUL_ROUND_NEAREST_EN; 0xF370 without.
- 0x7BFF x 0x7BFF → 0x7C00. 0x0400 x 0x0400 → 0x0000. 0x8000 x 0x3C00 → 0x8000.
- 0x0000 x 0x7C00 → 0x7E00. 0x7E01 x 0x3C00 → 0x7E00. 0x7C00 x 0xC000 → 0xFC00.
- Back-to-back pairs on 5 consecutive edges with tags 0-4:
  - Hold for 2 cycles mid-stream → all 5 results in order, each exactly once, held stable during hold.
- Assert rst with 3 ops in flight → out_Ready=0 the next cycle and no stale result appears afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, format widths and canonical
// special-value encodings for the pipelined multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    FpZero,
    FpNorm,
    FpInf,
    FpNan
  } fp_class_e;

  function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Builders return a 64-bit container; callers slice the low fp_width() bits.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int unsigned exp_w,
                                         input int unsigned man_w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[exp_w + man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational field split and classification of one operand.
// Subnormals are flushed to zero; the hidden bit is made explicit.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output fp_class_e            cls_o
);

  logic [MAN_W-1:0] man;

  always_comb begin
    sign_o = op_i[EXP_W+MAN_W];
    exp_o  = op_i[EXP_W+MAN_W-1:MAN_W];
    man    = op_i[MAN_W-1:0];
    sig_o  = {1'b1, man};
    if (exp_o == '0) begin
      cls_o = FpZero;
    end else if (exp_o == '1) begin
      cls_o = (man == '0) ? FpInf : FpNan;
    end else begin
      cls_o = FpNorm;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier, 3-cycle latency, 1 op/cycle, with tag sideband.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncation.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] in_A,
  input  logic [EXP_W+MAN_W:0] in_B,
  input  logic [TAG_W-1:0]     in_Tag,
  input  logic                 in_En,
  input  logic                 in_Hold,
  output logic [EXP_W+MAN_W:0] out_Out,
  output logic [TAG_W-1:0]     out_Tag,
  output logic                 out_Ready
);

  localparam int unsigned Width     = fp_width(EXP_W, MAN_W);
  localparam int unsigned Bias      = fp_bias(EXP_W);
  localparam int unsigned ExpMaxInt = (32'd1 << EXP_W) - 32'd1;
  localparam logic [63:0] QnanWide  = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0] InfWide   = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [Width-1:0] Qnan   = QnanWide[Width-1:0];
  localparam logic [Width-1:0] InfPos = InfWide[Width-1:0];
  localparam logic signed [EXP_W+1:0] BiasVec   = Bias[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] ExpMaxVec = ExpMaxInt[EXP_W+1:0];
  localparam int unsigned ProdW = 2 * MAN_W + 2;

  // Stage 1: unpack / classify / exponent sum
  logic                      sign_a, sign_b;
  logic [EXP_W-1:0]          exp_a, exp_b;
  logic [MAN_W:0]            sig_a, sig_b;
  fp_class_e                 cls_a, cls_b;

  logic                      s1_valid_d, s1_valid_q;
  logic [TAG_W-1:0]          s1_tag_d, s1_tag_q;
  logic                      s1_sign_d, s1_sign_q;
  fp_class_e                 s1_cls_d, s1_cls_q;
  logic signed [EXP_W+1:0]   s1_exp_d, s1_exp_q;
  logic [MAN_W:0]            s1_sig_a_d, s1_sig_a_q;
  logic [MAN_W:0]            s1_sig_b_d, s1_sig_b_q;

  // Stage 2: significand multiply and normalise
  logic [ProdW-1:0]          prod, norm;
  logic                      unused_hidden;

  logic                      s2_valid_d, s2_valid_q;
  logic [TAG_W-1:0]          s2_tag_d, s2_tag_q;
  logic                      s2_sign_d, s2_sign_q;
  fp_class_e                 s2_cls_d, s2_cls_q;
  logic signed [EXP_W+1:0]   s2_exp_d, s2_exp_q;
  logic [MAN_W-1:0]          s2_man_d, s2_man_q;
  logic                      s2_guard_d, s2_guard_q;
  logic                      s2_sticky_d, s2_sticky_q;

  // Stage 3: round, then range check and pack into the output register
  logic                      s3_valid_d, s3_valid_q;
  logic [TAG_W-1:0]          s3_tag_d, s3_tag_q;
  logic                      s3_sign_d, s3_sign_q;
  fp_class_e                 s3_cls_d, s3_cls_q;
  logic signed [EXP_W+1:0]   s3_exp_d, s3_exp_q;
  logic [MAN_W-1:0]          s3_man_d, s3_man_q;
  logic                      s3_uflow_d, s3_uflow_q;

  logic [Width-1:0]          packed_res, sign_mask;
  logic [Width-1:0]          out_d, out_q;
  logic [TAG_W-1:0]          tag_d, tag_q;
  logic                      ready_d, ready_q;

  fp_unpack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_unpack_a (
    .op_i  (in_A),
    .sign_o(sign_a),
    .exp_o (exp_a),
    .sig_o (sig_a),
    .cls_o (cls_a)
  );

  fp_unpack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_unpack_b (
    .op_i  (in_B),
    .sign_o(sign_b),
    .exp_o (exp_b),
    .sig_o (sig_b),
    .cls_o (cls_b)
  );

  always_comb begin
    s1_valid_d = in_En;
    s1_tag_d   = in_Tag;
    s1_sign_d  = sign_a ^ sign_b;
    s1_sig_a_d = sig_a;
    s1_sig_b_d = sig_b;
    s1_exp_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BiasVec;
    if (cls_a == FpNan || cls_b == FpNan ||
        (cls_a == FpZero && cls_b == FpInf) || (cls_a == FpInf && cls_b == FpZero)) begin
      s1_cls_d = FpNan;
    end else if (cls_a == FpInf || cls_b == FpInf) begin
      s1_cls_d = FpInf;
    end else if (cls_a == FpZero || cls_b == FpZero) begin
      s1_cls_d = FpZero;
    end else begin
      s1_cls_d = FpNorm;
    end
  end

  always_comb begin
    prod        = s1_sig_a_q * s1_sig_b_q;
    // Product is in [1,4); bring the leading one to the top bit.
    norm        = prod[ProdW-1] ? prod : (prod << 1);
    s2_valid_d  = s1_valid_q;
    s2_tag_d    = s1_tag_q;
    s2_sign_d   = s1_sign_q;
    s2_cls_d    = s1_cls_q;
    s2_exp_d    = s1_exp_q + $signed({{(EXP_W+1){1'b0}}, prod[ProdW-1]});
    s2_man_d    = norm[ProdW-2:MAN_W+1];
    s2_guard_d  = norm[MAN_W];
    s2_sticky_d = |norm[MAN_W-1:0];
  end

  assign unused_hidden = norm[ProdW-1];

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic           round_up;
  logic [MAN_W:0] man_rnd;

  always_comb begin
    round_up = s2_guard_q & (s2_sticky_q | s2_man_q[0]);
    man_rnd  = {1'b0, s2_man_q} + {{MAN_W{1'b0}}, round_up};
    s3_man_d = man_rnd[MAN_W-1:0];
    // A carry out leaves the mantissa at zero, i.e. 2.0 renormalised.
    s3_exp_d = s2_exp_q + $signed({{(EXP_W+1){1'b0}}, man_rnd[MAN_W]});
  end
`else
  logic unused_round;

  always_comb begin
    s3_man_d = s2_man_q;
    s3_exp_d = s2_exp_q;
  end

  assign unused_round = s2_guard_q ^ s2_sticky_q;
`endif

  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_tag_d   = s2_tag_q;
    s3_sign_d  = s2_sign_q;
    s3_cls_d   = s2_cls_q;
    s3_uflow_d = (s2_exp_q <= 0);
  end

  always_comb begin
    sign_mask = {s3_sign_q, {(Width-1){1'b0}}};
    unique case (s3_cls_q)
      FpNan:  packed_res = Qnan;
      FpInf:  packed_res = InfPos | sign_mask;
      FpZero: packed_res = sign_mask;
      FpNorm: begin
        if (s3_uflow_q) begin
          packed_res = sign_mask;
        end else if (s3_exp_q >= ExpMaxVec) begin
          packed_res = InfPos | sign_mask;
        end else begin
          packed_res = {s3_sign_q, s3_exp_q[EXP_W-1:0], s3_man_q};
        end
      end
    endcase
    ready_d = s3_valid_q;
    out_d   = s3_valid_q ? packed_res : out_q;
    tag_d   = s3_valid_q ? s3_tag_q : tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= FpZero;
      s1_exp_q    <= '0;
      s1_sig_a_q  <= '0;
      s1_sig_b_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= FpZero;
      s2_exp_q    <= '0;
      s2_man_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_tag_q    <= '0;
      s3_sign_q   <= 1'b0;
      s3_cls_q    <= FpZero;
      s3_exp_q    <= '0;
      s3_man_q    <= '0;
      s3_uflow_q  <= 1'b0;
      out_q       <= '0;
      tag_q       <= '0;
      ready_q     <= 1'b0;
    end else if (!in_Hold) begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_exp_q    <= s1_exp_d;
      s1_sig_a_q  <= s1_sig_a_d;
      s1_sig_b_q  <= s1_sig_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_exp_q    <= s2_exp_d;
      s2_man_q    <= s2_man_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      s3_valid_q  <= s3_valid_d;
      s3_tag_q    <= s3_tag_d;
      s3_sign_q   <= s3_sign_d;
      s3_cls_q    <= s3_cls_d;
      s3_exp_q    <= s3_exp_d;
      s3_man_q    <= s3_man_d;
      s3_uflow_q  <= s3_uflow_d;
      out_q       <= out_d;
      tag_q       <= tag_d;
      ready_q     <= ready_d;
    end
  end

  assign out_Out   = out_q;
  assign out_Tag   = tag_q;
  assign out_Ready = ready_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe at the default half-precision format.
module tb_fp_mul_pipe;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned TAG_W = 4;

`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam logic [15:0] ExpRnd = 16'hF371;
`else
  localparam logic [15:0] ExpRnd = 16'hF370;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_A, in_B;
  logic [3:0]  in_Tag;
  logic        in_En, in_Hold;
  logic [15:0] out_Out;
  logic [3:0]  out_Tag;
  logic        out_Ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .TAG_W(TAG_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_A     (in_A),
    .in_B     (in_B),
    .in_Tag   (in_Tag),
    .in_En    (in_En),
    .in_Hold  (in_Hold),
    .out_Out  (out_Out),
    .out_Tag  (out_Tag),
    .out_Ready(out_Ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for its result and check value, tag and latency.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] exp_out);
    int   lat;
    logic seen;
    in_A   = a;
    in_B   = b;
    in_Tag = tag;
    in_En  = 1'b1;
    @(posedge clk);
    #1;
    in_En = 1'b0;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      seen = out_Ready;
    end
    check({name, "_lat"}, 32'(lat), 32'd3);
    check(name, 32'(out_Out), 32'(exp_out));
    check({name, "_tag"}, 32'(out_Tag), 32'(tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s_a[5];
    logic [15:0] s_b[5];
    logic [15:0] s_exp[5];
    int          sched_op[7];
    logic        sched_hold[7];
    logic        pend, stable;
    logic [15:0] pend_out;
    logic [3:0]  pend_tag;
    int          rcv;

    s_a   = '{16'h4000, 16'h4200, 16'h3800, 16'hC000, 16'h3C00};
    s_b   = '{16'h4000, 16'h4000, 16'h4400, 16'h4200, 16'h3C00};
    s_exp = '{16'h4400, 16'h4600, 16'h4000, 16'hC600, 16'h3C00};
    sched_op   = '{0, 1, 2, 3, -1, -1, 4};
    sched_hold = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst     = 1'b1;
    in_A    = '0;
    in_B    = '0;
    in_Tag  = '0;
    in_En   = 1'b0;
    in_Hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(out_Ready), 32'd0);
    check("rst_out", 32'(out_Out), 32'd0);
    check("rst_tag", 32'(out_Tag), 32'd0);
    rst = 1'b0;

    run_op("one", 16'h3C00, 16'h3C00, 4'd3, 16'h3C00);
    run_op("rnd", 16'h57B7, 16'hD7B7, 4'd5, ExpRnd);
    run_op("ovf", 16'h7BFF, 16'h7BFF, 4'd6, 16'h7C00);
    run_op("uflw", 16'h0400, 16'h0400, 4'd7, 16'h0000);
    run_op("negz", 16'h8000, 16'h3C00, 4'd8, 16'h8000);
    run_op("zinf", 16'h0000, 16'h7C00, 4'd9, 16'h7E00);
    run_op("nan", 16'h7E01, 16'h3C00, 4'd10, 16'h7E00);
    run_op("infneg", 16'h7C00, 16'hC000, 4'd11, 16'hFC00);

    // Stream with a two-cycle hold while a result is presented.
    pend     = 1'b0;
    stable   = 1'b0;
    pend_out = '0;
    pend_tag = '0;
    rcv      = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 7) begin
        in_Hold = sched_hold[i];
        in_En   = 1'b1;
        if (sched_op[i] >= 0) begin
          in_A   = s_a[sched_op[i]];
          in_B   = s_b[sched_op[i]];
          in_Tag = 4'(sched_op[i]);
        end else begin
          in_A   = 16'h3C00;
          in_B   = 16'h3C00;
          in_Tag = 4'hF;
        end
      end else begin
        in_Hold = 1'b0;
        in_En   = 1'b0;
      end
      if (pend) begin
        if (!in_Hold) begin
          if (rcv < 5) begin
            check("s_out", 32'(pend_out), 32'(s_exp[rcv]));
            check("s_tag", 32'(pend_tag), 32'(rcv));
          end
          rcv++;
        end else begin
          stable = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (stable) begin
        check("hold_ready", 32'(out_Ready), 32'd1);
        check("hold_out", 32'(out_Out), 32'(pend_out));
        check("hold_tag", 32'(out_Tag), 32'(pend_tag));
        stable = 1'b0;
      end
      pend     = out_Ready;
      pend_out = out_Out;
      pend_tag = out_Tag;
    end
    check("s_count", 32'(rcv), 32'd5);

    // Reset with three ops in flight must discard all of them.
    in_Hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_A   = 16'h4000;
      in_B   = 16'h4000;
      in_Tag = 4'(i + 1);
      in_En  = 1'b1;
      @(posedge clk);
      #1;
    end
    in_En = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_ready", 32'(out_Ready), 32'd0);
    check("rstmid_out", 32'(out_Out), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_stale", 32'(out_Ready), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
